// File: rtl/sklansky_adder_pipe.sv
// Pipelined two's-complement adder/subtractor on a Sklansky parallel-prefix carry network.
// Position 0 of the prefix vectors is the carry-in (bit -1); position i+1 is operand bit i.
// STAGES register stages with a valid/ready handshake and full backpressure.
module sklansky_adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N      = WIDTH + 1;
  localparam int unsigned LEVELS = $clog2(N);
  localparam int unsigned NREG   = (STAGES > 1) ? STAGES - 1 : 1;

  // Returns the intermediate stage whose register sits after prefix level lvl (0 if none).
  function automatic int unsigned stage_after(input int unsigned lvl);
    int unsigned k_hit;
    k_hit = 0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if ((k * LEVELS + STAGES - 1) / STAGES == lvl) k_hit = k;
    end
    return k_hit;
  endfunction

  logic [STAGES:1]             vld;
  logic [STAGES:0]             vin;
  logic [STAGES:1]             rdy;
  logic                        rdy_acc;

  logic [NREG-1:0][N-1:0]      cap_g;
  logic [NREG-1:0][N-1:0]      cap_p;
  logic [NREG-1:0][WIDTH-1:0]  cap_pv;
  logic [NREG-1:0][N-1:0]      pipe_g;
  logic [NREG-1:0][N-1:0]      pipe_p;
  logic [NREG-1:0][WIDTH-1:0]  pipe_pv;

  logic [WIDTH-1:0]            b_eff;
  logic                        c0;
  logic [N-1:0]                g_w;
  logic [N-1:0]                p_w;
  logic [N-1:0]                g_nx;
  logic [N-1:0]                p_nx;
  logic [WIDTH-1:0]            pv_w;
  int unsigned                 sk;

  logic [WIDTH-1:0]            sum_nx;
  logic                        cout_nx;
  logic                        ovf_nx;

  // Incoming valid of each stage: stage k is fed by stage k-1, stage 1 by the input port.
  assign vin       = {vld, in_valid};
  assign in_ready  = rdy[1];
  assign out_valid = vld[STAGES];

  // Combinational ready chain from the output back to the input; no bubbles.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int k = int'(STAGES); k >= 1; k--) begin
      rdy_acc = ~vld[k] | rdy_acc;
      rdy[k]  = rdy_acc;
    end
  end

  // Operand conditioning, prefix levels with register cut points, and result formation.
  always_comb begin
    cap_g  = '0;
    cap_p  = '0;
    cap_pv = '0;
    sk     = 0;
    g_nx   = '0;
    p_nx   = '0;
    b_eff  = b ^ {WIDTH{sub}};
    c0     = sub | cin;
    pv_w   = a ^ b_eff;
    g_w    = {a & b_eff, c0};
    p_w    = {pv_w, 1'b0};
    for (int unsigned l = 0; l < LEVELS; l++) begin
      g_nx = g_w;
      p_nx = p_w;
      for (int unsigned i = 0; i < N; i++) begin
        if (((i >> l) & 1) != 0) begin
          g_nx[i] = g_w[i] | (p_w[i] & g_w[((i >> l) << l) - 1]);
          p_nx[i] = p_w[i] & p_w[((i >> l) << l) - 1];
        end
      end
      g_w = g_nx;
      p_w = p_nx;
      sk  = stage_after(l + 1);
      if (sk != 0) begin
        cap_g[sk-1]  = g_w;
        cap_p[sk-1]  = p_w;
        cap_pv[sk-1] = pv_w;
        g_w          = pipe_g[sk-1];
        p_w          = pipe_p[sk-1];
        pv_w         = pipe_pv[sk-1];
      end
    end
    sum_nx  = pv_w ^ g_w[WIDTH-1:0];
    cout_nx = g_w[WIDTH];
    ovf_nx  = g_w[WIDTH] ^ g_w[WIDTH-1];
  end

  // Stage valid bits: load from upstream whenever the stage is ready, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 1; k <= int'(STAGES); k++) begin
        if (rdy[k]) vld[k] <= vin[k-1];
      end
    end
  end

  // Output data register, cleared by reset and held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (rdy[STAGES] && vin[STAGES-1]) begin
      sum  <= sum_nx;
      cout <= cout_nx;
      ovf  <= ovf_nx;
    end
  end

  // Intermediate (G,P,p) registers; data only, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 1; k < int'(STAGES); k++) begin
      if (rdy[k] && vin[k-1]) begin
        pipe_g[k-1]  <= cap_g[k-1];
        pipe_p[k-1]  <= cap_p[k-1];
        pipe_pv[k-1] <= cap_pv[k-1];
      end
    end
  end

endmodule
